uart_rx: RTL and testbench

- UART receiver: 8 data bits, no parity, 1 stop bit, LSB first; the receive-side counterpart of the peripheral's transmitter.
- Synchronises the asynchronous rx line, validates the start bit at mid-bit and samples each data bit at mid-bit.
- Holds the received byte for the bus wrapper until it is read.
- Flags framing errors and overruns.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, no parity, 1 stop bit, LSB first.
// The rx line is double-synchronised and every bit is sampled at mid-bit.
module uart_rx #(
    parameter int CLOCK_SCALE_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
    input  logic                        rx,
    output logic                        busy,
    output logic [7:0]                  dataOut,
    output logic                        dataAvailable,
    input  logic                        dataRead,
    output logic                        overrunError,
    output logic                        framingError
);

    // state | meaning
    // IDLE  | waiting for a falling edge on the synchronised line
    // START | counting to mid start bit to reject glitches
    // DATA  | sampling 8 data bits at mid-bit
    // STOP  | sampling the stop bit, then publishing or discarding the byte
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam logic [CLOCK_SCALE_BITS-1:0] ONE = CLOCK_SCALE_BITS'(1);

    state_e                      state_q, state_d;
    logic [CLOCK_SCALE_BITS-1:0] delay_q, delay_d;
    logic [2:0]                  bit_q, bit_d;
    logic [7:0]                  shift_q, shift_d;
    logic [7:0]                  data_q, data_d;
    logic                        avail_q, avail_d;
    logic                        overrun_q, overrun_d;
    logic                        ferr_q, ferr_d;
    logic                        sync1_q, rx_sync_q, rx_prev_q;

    logic [CLOCK_SCALE_BITS-1:0] half_bit;
    logic [CLOCK_SCALE_BITS-1:0] delay_inc;

    assign half_bit  = cyclesPerBit >> 1;
    assign delay_inc = delay_q + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx;
            rx_sync_q <= sync1_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            delay_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            avail_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            avail_q   <= avail_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        avail_d   = avail_q;
        overrun_d = overrun_q;
        ferr_d    = 1'b0;

        if (dataRead && avail_q) begin
            avail_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                delay_d = '0;
                bit_d   = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                delay_d = delay_inc;
                if (delay_inc == half_bit) begin
                    delay_d = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                delay_d = delay_inc;
                if (delay_inc == cyclesPerBit) begin
                    delay_d        = '0;
                    shift_d[bit_q] = rx_sync_q;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                delay_d = delay_inc;
                if (delay_inc == cyclesPerBit) begin
                    delay_d = '0;
                    state_d = IDLE;
                    if (rx_sync_q) begin
                        data_d  = shift_q;
                        avail_d = 1'b1;
                        // A read landing on the completion cycle consumes the old byte, so no overrun.
                        if (avail_q && !dataRead) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign dataOut       = data_q;
    assign dataAvailable = avail_q;
    assign overrunError  = overrun_q;
    assign framingError  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frame outcomes,
// a negedge monitor pops and compares whenever a frame ends (busy falls).
`timescale 1ns/1ps
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cyclesPerBit;
    logic        rx;
    logic        busy;
    logic [7:0]  dataOut;
    logic        dataAvailable;
    logic        dataRead;
    logic        overrunError;
    logic        framingError;

    uart_rx #(.CLOCK_SCALE_BITS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cyclesPerBit (cyclesPerBit),
        .rx           (rx),
        .busy         (busy),
        .dataOut      (dataOut),
        .dataAvailable(dataAvailable),
        .dataRead     (dataRead),
        .overrunError (overrunError),
        .framingError (framingError)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       avail;
        logic       ovr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the byte-holding register as seen by the bus.
    logic [7:0] m_data  = 8'h00;
    logic       m_avail = 1'b0;
    logic       m_ovr   = 1'b0;
    int         cpb_cur = 16;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame outcome is decided from the UART rules: a 1 stop bit publishes the
    // byte, a 0 stop bit raises a framing error and leaves the register alone.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rd, input int tail_low);
        int   c0;
        int   half;
        bit   brk;
        exp_t e;
        half  = cpb_cur / 2;
        c0    = cyc;
        e.cyc = c0 + 3 + half + 9 * cpb_cur;
        if (stop_ok) begin
            if (rd) m_ovr = m_avail ? 1'b0 : m_ovr;
            else    m_ovr = m_avail ? 1'b1 : m_ovr;
            m_avail = 1'b1;
            m_data  = b;
            e.ferr  = 1'b0;
        end else begin
            e.ferr  = 1'b1;
        end
        e.data  = m_data;
        e.avail = m_avail;
        e.ovr   = m_ovr;
        exp_q.push_back(e);

        rx = 1'b0;
        wait_cycles(cpb_cur);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(cpb_cur);
        end
        rx = stop_ok;
        for (int k = 0; k < cpb_cur; k++) begin
            dataRead = rd && ((cyc - c0) == (2 + half + 9 * cpb_cur));
            wait_cycles(1);
        end
        dataRead = 1'b0;
        if (!stop_ok) begin
            if (tail_low > 0) begin
                brk = 1'b0;
                repeat (tail_low) begin
                    if (busy) brk = 1'b1;
                    wait_cycles(1);
                end
                check("break_no_start", {31'd0, brk}, 32'd0);
            end
            rx = 1'b1;
            wait_cycles(3);
        end
    endtask

    task automatic glitch(input int len);
        int   half;
        exp_t e;
        half    = cpb_cur / 2;
        e.cyc   = cyc + 3 + half;
        e.data  = m_data;
        e.avail = m_avail;
        e.ovr   = m_ovr;
        e.ferr  = 1'b0;
        exp_q.push_back(e);
        rx = 1'b0;
        wait_cycles(len);
        rx = 1'b1;
        wait_cycles(half + 4);
    endtask

    task automatic do_read();
        dataRead = 1'b1;
        wait_cycles(1);
        dataRead = 1'b0;
        if (m_avail) begin
            m_avail = 1'b0;
            m_ovr   = 1'b0;
        end
        check("read_avail",   {31'd0, dataAvailable}, {31'd0, m_avail});
        check("read_overrun", {31'd0, overrunError},  {31'd0, m_ovr});
        check("read_data",    {24'd0, dataOut},       {24'd0, m_data});
    endtask

    task automatic set_cpb(input int v);
        wait_cycles(2 * cpb_cur + 8);
        cpb_cur      = v;
        cyclesPerBit = v[15:0];
        wait_cycles(2);
    endtask

    // Monitor: every end of frame (busy falling) must match the next queued outcome.
    bit busy_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame_end: got busy fall at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("end_cycle", cyc,                     e.cyc);
                    check("data_out",  {24'd0, dataOut},       {24'd0, e.data});
                    check("data_avail",{31'd0, dataAvailable}, {31'd0, e.avail});
                    check("overrun",   {31'd0, overrunError},  {31'd0, e.ovr});
                    check("framing",   {31'd0, framingError},  {31'd0, e.ferr});
                end
            end else if (framingError) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_framing_pulse: got 1 expected 0 at cycle %0d", cyc);
            end
            busy_prev = busy;
        end
    end

    initial begin
        logic [7:0] part;
        int         r;
        rst          = 1'b1;
        rx           = 1'b1;
        dataRead     = 1'b0;
        cyclesPerBit = 16'd16;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",    {31'd0, busy},          32'd0);
        check("reset_data",    {24'd0, dataOut},       32'd0);
        check("reset_avail",   {31'd0, dataAvailable}, 32'd0);
        check("reset_overrun", {31'd0, overrunError},  32'd0);
        check("reset_framing", {31'd0, framingError},  32'd0);
        rst = 1'b0;
        wait_cycles(3);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        wait_cycles(20);
        do_read();

        send_frame(8'h3C, 1'b1, 1'b0, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 0);
        wait_cycles(20);
        do_read();

        glitch(3);
        check("glitch_avail", {31'd0, dataAvailable}, 32'd0);

        send_frame(8'h55, 1'b0, 1'b0, 40);
        check("break_data_kept", {24'd0, dataOut}, {24'd0, m_data});

        set_cpb(5);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        send_frame(8'h00, 1'b1, 1'b1, 0);
        wait_cycles(10);

        for (int g = 0; g < 4; g++) begin
            set_cpb($urandom_range(12, 4));
            for (int f = 0; f < 6; f++) begin
                r = $urandom_range(7, 0);
                if (r == 0) begin
                    glitch($urandom_range(cpb_cur / 2, 1));
                end else begin
                    send_frame(8'($urandom), r != 1, (r >= 6) && (cpb_cur >= 5), 0);
                end
                wait_cycles($urandom_range(2, 0));
                if ($urandom_range(3, 0) == 0) begin
                    wait_cycles(2);
                    do_read();
                end
            end
        end

        set_cpb(16);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        wait_cycles(5);
        part = 8'hC6;
        rx   = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 4; i++) begin
            rx = part[i];
            wait_cycles(16);
        end
        rx = part[4];
        wait_cycles(8);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy",    {31'd0, busy},          32'd0);
        check("async_rst_data",    {24'd0, dataOut},       32'd0);
        check("async_rst_avail",   {31'd0, dataAvailable}, 32'd0);
        check("async_rst_overrun", {31'd0, overrunError},  32'd0);
        check("async_rst_framing", {31'd0, framingError},  32'd0);
        m_data  = 8'h00;
        m_avail = 1'b0;
        m_ovr   = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(3);
        send_frame(8'h0F, 1'b1, 1'b0, 0);
        wait_cycles(40);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
